// File: rtl/std_mult_seq.sv
// std_mult_seq: iterative shift-add unsigned multiplier.
// One partial product per cycle; low width bits of left*right.
module std_mult_seq #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [width-1:0] left,
  input  logic             left_read_in,
  input  logic [width-1:0] right,
  input  logic             right_read_in,
  input  logic             valid,
  output logic             ready,
  output logic [width-1:0] out,
  output logic             out_read_out
);

  localparam int CW = $clog2(width + 1);
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [width-1:0] mcand;
  logic [width-1:0] mplier;
  logic [width-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [width-1:0] res;
  logic [width-1:0] sum;
  logic             go;

  // Accumulator value after this cycle's conditional add.
  always_comb begin
    sum = acc;
    if (mplier[0]) sum = acc + mcand;
  end

  assign go = valid & left_read_in & right_read_in;

  // Sequencer: accept, iterate width times, pulse ready once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      res    <= '0;
      ready  <= 1'b0;
    end else begin
      ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            mcand  <= left;
            mplier <= right;
            acc    <= '0;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (!valid) begin
            state <= IDLE;
          end else begin
            acc    <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (cnt == LAST) begin
              res   <= sum;
              ready <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign out          = res;
  assign out_read_out = ready;

endmodule

// File: tb/tb_std_mult_seq.sv
// tb_std_mult_seq: randomized checks of std_mult_seq
// against a plain-arithmetic product and latency model.
module tb_std_mult_seq;

  logic        clk;
  logic        reset_n;

  logic [7:0]  l8, r8, out8;
  logic        lv8, rv8, v8, rdy8, ord8;

  logic [31:0] l32, r32, out32;
  logic        lv32, rv32, v32, rdy32, ord32;

  int vec;
  int errs;

  std_mult_seq #(.width(8)) dut8 (
    .clk          (clk),
    .reset_n      (reset_n),
    .left         (l8),
    .left_read_in (lv8),
    .right        (r8),
    .right_read_in(rv8),
    .valid        (v8),
    .ready        (rdy8),
    .out          (out8),
    .out_read_out (ord8)
  );

  std_mult_seq #(.width(32)) dut32 (
    .clk          (clk),
    .reset_n      (reset_n),
    .left         (l32),
    .left_read_in (lv32),
    .right        (r32),
    .right_read_in(rv32),
    .valid        (v32),
    .ready        (rdy32),
    .out          (out32),
    .out_read_out (ord32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] prod8(input logic [7:0] a, b);
    int p;
    p = int'(a) * int'(b);
    return p[7:0];
  endfunction

  function automatic logic [31:0] prod32(input logic [31:0] a, b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[31:0];
  endfunction

  // One width-8 product from IDLE; operands scrambled while busy.
  task automatic op8(input logic [7:0] a, b, input string nm);
    logic [7:0] e;
    logic       er;
    e = prod8(a, b);
    l8 = a; r8 = b; lv8 = 1; rv8 = 1; v8 = 1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      er = (k == 9);
      vec++;
      if (rdy8 !== er || ord8 !== er) begin
        errs++;
        $display("FAIL %s ready c%0d: got %b/%b want %b",
                 nm, k, rdy8, ord8, er);
      end
      if (k >= 9) begin
        vec++;
        if (out8 !== e) begin
          errs++;
          $display("FAIL %s out c%0d: got %h want %h",
                   nm, k, out8, e);
        end
      end
      if (k <= 8) begin
        l8 = 8'($urandom); r8 = 8'($urandom);
        lv8 = 1'($urandom); rv8 = 1'($urandom);
      end
      if (k == 9) v8 = 0;
    end
  endtask

  task automatic test_reset();
    reset_n = 0;
    l8 = 0; r8 = 0; lv8 = 0; rv8 = 0; v8 = 0;
    l32 = 0; r32 = 0; lv32 = 0; rv32 = 0; v32 = 0;
    tick(); tick();
    vec++;
    if (rdy8 !== 0 || ord8 !== 0 || out8 !== 0) begin
      errs++;
      $display("FAIL reset8: got %b %b %h want 0 0 0",
               rdy8, ord8, out8);
    end
    vec++;
    if (rdy32 !== 0 || ord32 !== 0 || out32 !== 0) begin
      errs++;
      $display("FAIL reset32: got %b %b %h want 0 0 0",
               rdy32, ord32, out32);
    end
    reset_n = 1;
    tick();
  endtask

  task automatic test_basic();
    op8(8'd3, 8'd5, "3x5");
    op8(8'd255, 8'd255, "255x255");
    op8(8'd0, 8'd200, "0x200");
  endtask

  task automatic test_read_in_wait();
    l8 = 8'd11; r8 = 8'd13; lv8 = 1; rv8 = 0; v8 = 1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      vec++;
      if (rdy8 !== 1'(k == 12)) begin
        errs++;
        $display("FAIL rdwait ready c%0d: got %b want %b",
                 k, rdy8, (k == 12));
      end
      if (k == 12) begin
        vec++;
        if (out8 !== prod8(8'd11, 8'd13)) begin
          errs++;
          $display("FAIL rdwait out: got %h want %h",
                   out8, prod8(8'd11, 8'd13));
        end
        v8 = 0;
      end
      if (k == 3) rv8 = 1;
    end
  endtask

  task automatic test_abort();
    op8(8'd3, 8'd5, "pre");
    l8 = 8'd7; r8 = 8'd9; lv8 = 1; rv8 = 1; v8 = 1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      vec++;
      if (rdy8 !== 0 || out8 !== 8'd15) begin
        errs++;
        $display("FAIL abort c%0d: got %b %h want 0 0f",
                 k, rdy8, out8);
      end
      if (k == 4) v8 = 0;
    end
  endtask

  task automatic test_reset_mid();
    l8 = 8'd6; r8 = 8'd7; lv8 = 1; rv8 = 1; v8 = 1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 5) begin
        reset_n = 0;
        #1;
        vec++;
        if (out8 !== 0 || rdy8 !== 0) begin
          errs++;
          $display("FAIL midreset: got %h %b want 0 0",
                   out8, rdy8);
        end
        reset_n = 1;
      end else begin
        vec++;
        if (rdy8 !== 1'(k == 14)) begin
          errs++;
          $display("FAIL midreset ready c%0d: got %b want %b",
                   k, rdy8, (k == 14));
        end
        if (k == 14) begin
          vec++;
          if (out8 !== 8'd42) begin
            errs++;
            $display("FAIL midreset out: got %h want 2a", out8);
          end
          v8 = 0;
        end
      end
    end
  endtask

  task automatic test_random8();
    for (int i = 0; i < 12; i++)
      op8(8'($urandom), 8'($urandom), "rand8");
  endtask

  // Back-to-back width-32 products with valid held high.
  task automatic run32(input logic [31:0] la[$],
                       input logic [31:0] ra[$],
                       input string nm);
    int n;
    int ph;
    logic [31:0] e;
    n = la.size();
    l32 = la[0]; r32 = ra[0];
    lv32 = 1; rv32 = 1; v32 = 1;
    for (int k = 1; k <= n * 34; k++) begin
      tick();
      ph = k % 34;
      vec++;
      if (rdy32 !== 1'(ph == 33) || ord32 !== 1'(ph == 33)) begin
        errs++;
        $display("FAIL %s ready c%0d: got %b/%b want %b",
                 nm, k, rdy32, ord32, (ph == 33));
      end
      if (ph == 33) begin
        e = prod32(la[k / 34], ra[k / 34]);
        vec++;
        if (out32 !== e) begin
          errs++;
          $display("FAIL %s out c%0d: got %h want %h",
                   nm, k, out32, e);
        end
        if (k / 34 + 1 < n) begin
          l32 = la[k / 34 + 1];
          r32 = ra[k / 34 + 1];
          lv32 = 1; rv32 = 1;
        end else begin
          v32 = 0;
        end
      end else if (ph != 0) begin
        l32 = $urandom; r32 = $urandom;
        lv32 = 1'($urandom); rv32 = 1'($urandom);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] la[$];
    logic [31:0] ra[$];
    la = {32'h0001_0000, 32'd12345};
    ra = {32'h0001_0001, 32'd6789};
    run32(la, ra, "b2b32");
  endtask

  task automatic test_random32();
    logic [31:0] la[$];
    logic [31:0] ra[$];
    for (int i = 0; i < 8; i++) begin
      la.push_back($urandom);
      ra.push_back($urandom);
    end
    la.push_back(32'hFFFF_FFFF);
    ra.push_back(32'hFFFF_FFFF);
    run32(la, ra, "rand32");
  endtask

  initial begin
    vec = 0;
    errs = 0;
    test_reset();
    test_basic();
    test_read_in_wait();
    test_abort();
    test_reset_mid();
    test_random8();
    test_back_to_back();
    test_random32();
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end

endmodule

// File: doc/std_mult_seq.md
# std_mult_seq

Iterative shift-add unsigned multiplier with a valid/ready handshake. It takes `width` cycles to compute the low `width` bits of `left * right`. It is the multi-cycle counterpart of the combinational arithmetic primitives and sits directly upstream of `std_reg`: its `out`/`out_read_out` pair drives a register's `in`/`in_read_in`. Its operand ports accept the `out`/`out_read_out` pairs of `std_const`, `std_reg` or `std_add`.

## Interface
- `width`, default 32: operand and result width in bits; must be ≥ 2.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `left` input `width`: multiplicand.
- `left_read_in` input 1: `left` carries a valid value this cycle.
- `right` input `width`: multiplier.
- `right_read_in` input 1: `right` carries a valid value this cycle.
- `valid` input 1: go; held high by the controller until `ready` is seen.
- `ready` output 1: done; high for exactly one cycle per completed product.
- `out` output `width`: result register, `(left * right) mod 2^width`; holds its value between operations.
- `out_read_out` output 1: `out` is a fresh result this cycle; identical to `ready`.

## Operation
- Internal state:
  - FSM with states IDLE, BUSY, DONE.
  - Multiplicand shift register `mcand`, `width` bits.
  - Multiplier shift register `mplier`, `width` bits.
  - Accumulator `acc`, `width` bits.
  - Iteration counter `cnt`, `$clog2(width+1)` bits.
  - Result register driving `out`.
- IDLE:
  - If `valid && left_read_in && right_read_in`: `mcand <= left`, `mplier <= right`, `acc <= 0`, `cnt <= 0`, go to BUSY.
  - Otherwise stay in IDLE; operands are ignored.
- BUSY, each cycle `valid` is high:
  - If `mplier[0]`, then `acc <= acc + mcand`, truncated to `width` bits.
  - `mcand <= mcand << 1`, zero-fill, bits shifted out are dropped.
  - `mplier <= mplier >> 1`.
  - `cnt <= cnt + 1`.
  - When `cnt == width-1` is processed: the result register takes the final accumulator value, including this cycle's add, and the FSM goes to DONE.
- BUSY with `valid` low: abort. Go to IDLE; the result register is unchanged; `ready` stays low.
- DONE:
  - `ready = out_read_out = 1` for this one cycle.
  - Next state is IDLE unconditionally, regardless of `valid`.
- Operands are sampled only on the IDLE accept edge. Changes on `left`/`right`/`*_read_in` during BUSY have no effect.
- There is no early termination: latency is fixed even when operands are zero.
- Arithmetic is unsigned. The result equals `std_mul`'s truncated product for all operand pairs.

## Timing
- Reset (`reset_n` low, asynchronous, immediate): state IDLE; `ready=0`, `out_read_out=0`, `out=0`; `acc`, `mcand`, `mplier`, `cnt` = 0.
- Reset release: first accept is possible on the first rising edge with `reset_n` high.
- Reset asserted mid-operation: the operation is discarded; `out` returns to 0; no `ready` pulse.
- Latency: if `valid` and both read_ins are high in cycle 0 while in IDLE, then BUSY covers cycles 1..`width`, DONE (`ready` high) is cycle `width+1`, and IDLE is cycle `width+2`.
- New `out` is visible in the DONE cycle and is held until the next DONE or reset.
- Throughput: one product per `width+2` cycles.
  - If `valid` stays high after DONE, a new operation is accepted in the IDLE cycle (`width+2`).
  - The DONE cycle never accepts.
- `valid` high with either read_in low in IDLE: no accept; FSM waits and `ready` stays low.
- `ready` is registered (decoded from state only); it never depends combinationally on inputs.

## Test plan
- `width=8`, `left=3`, `right=5`, both read_ins and `valid` high in cycle 0 -> `ready`/`out_read_out` high only in cycle 9 with `out=15`, FSM in IDLE in cycle 10, `out` still 15.
- `width=8`, `255*255` -> `out=8'h01` in cycle 9; `0*200` -> `out=0`, also in cycle 9 (no early exit).
- `width=8`, `valid` high but `right_read_in` low for cycles 0-2, then high in cycle 3 -> accept in cycle 3, `ready` in cycle 12, no `ready` before that.
- `width=8`, product 15 completed, then start `7*9` with `valid` dropped in cycle 4 -> FSM in IDLE in cycle 5, no `ready` pulse, `out` remains 15.
- `width=8`, `reset_n` pulsed low in cycle 5 of `6*7` -> `out=0`, `ready=0` immediately; a new accept after release yields `ready` exactly 9 cycles later.
- `width=32`, `valid` held high continuously with operands `0x0001_0000 * 0x0001_0001` then `12345*6789` -> results `0x0001_0000` at cycle 33 and `83810205` at cycle 67; randomized sweep matches `(l*r) mod 2^32`.
